// File: rtl/cache_mem_arbiter_pkg.sv
// ============================================================================
// Module : arb_types (package)
// Brief  : Shared state encoding and line width for the cache/memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arb_types;

    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module : cache_mem_arbiter
// Brief  : Shares one pmem port between I-cache fills and D-cache fills/writebacks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic              d_req, i_req;
    logic              grant_i, grant_d;

    always_comb begin
        d_req       = d_pmem_read | d_pmem_write;
        i_req       = i_pmem_read;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        state_d     = state_q;
        starve_d    = starve_q;
        read_d      = read_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req && (starve_q == STARVE_MAX)) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end

                if (grant_i) begin
                    state_d  = SERVE_I;
                    starve_d = 4'd0;
                    read_d   = 1'b1;
                    write_d  = 1'b0;
                    addr_d   = i_pmem_address;
                end else if (grant_d) begin
                    state_d  = SERVE_D;
                    // Count only D grants that actually made I wait.
                    if (i_req) begin
                        starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                    write_d  = d_pmem_write;
                    read_d   = ~d_pmem_write;
                    addr_d   = d_pmem_address;
                    if (d_pmem_write) begin
                        wdata_d = d_pmem_wdata;
                    end
                end
            end
            SERVE_I: begin
                i_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            SERVE_D: begin
                d_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            read_q   <= read_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_addr    = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // Dual read+write from the D-cache is serviced as a write; flag it in simulation.
    always @(posedge clk) begin
        if (!rst && grant_d) begin
            assert (!(d_pmem_read && d_pmem_write))
                else $warning("cache_mem_arbiter: D read and write both set, servicing write");
        end
        assert (!(read_q && write_q))
            else $error("cache_mem_arbiter: pmem_read and pmem_write both high");
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
// Module : tb_cache_mem_arbiter
// Brief  : Directed self-checking bench for cache_mem_arbiter with an 8-cycle adaptor model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int ADP_LAT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              adp_resp;
    logic              spur_resp;

    int vectors     = 0;
    int miscompares = 0;

    logic [LINE_W-1:0] pat_a, pat_b, pat_c, pat_d;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_addr      (pmem_addr),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (adp_resp | spur_resp)
    );

    always #5 clk = ~clk;

    // Adaptor model: acknowledges a held request on its ADP_LAT-th falling edge.
    initial begin
        int cnt;
        cnt      = 0;
        adp_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                adp_resp = 1'b0;
                cnt      = 0;
            end else if (adp_resp) begin
                adp_resp = 1'b0;
                cnt      = 0;
            end else if (pmem_read || pmem_write) begin
                cnt = cnt + 1;
                if (cnt == ADP_LAT) adp_resp = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit want_i, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (want_i ? i_pmem_resp : d_pmem_resp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (pmem_read || pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        vectors++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        end
        vectors++;
        if (pmem_addr !== '0 || pmem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h wdata %h want 0", pmem_addr, pmem_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_i_read();
        bit ok;
        pmem_rdata     = pat_a;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0060;
        step();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h60) begin
            miscompares++;
            $display("FAIL i_grant: rd %b wr %b addr %h want 1 0 00000060", pmem_read, pmem_write, pmem_addr);
        end
        wait_resp(1'b1, ok);
        vectors++;
        if (!ok || i_pmem_rdata !== pat_a || d_pmem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL i_resp: seen %b d_resp %b rdata_ok %b want 1 0 1", ok, d_pmem_resp, i_pmem_rdata === pat_a);
        end
        i_pmem_read = 1'b0;
        step();
        vectors++;
        if (i_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL i_pulse: resp %b rd %b want 0 0", i_pmem_resp, pmem_read);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        pmem_rdata     = pat_d;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0080;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata   = pat_b;
        step();
        vectors++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h1000 || pmem_wdata !== pat_b) begin
            miscompares++;
            $display("FAIL d_first: rd %b wr %b addr %h wdata_ok %b want 0 1 00001000 1",
                     pmem_read, pmem_write, pmem_addr, pmem_wdata === pat_b);
        end
        wait_resp(1'b0, ok);
        vectors++;
        if (!ok || i_pmem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL d_write_resp: seen %b i_resp %b want 1 0", ok, i_pmem_resp);
        end
        d_pmem_write = 1'b0;
        step();
        step();
        vectors++;
        if (pmem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL turnaround_early: rd %b want 0", pmem_read);
        end
        step();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL turnaround_i: rd %b addr %h want 1 00000080", pmem_read, pmem_addr);
        end
        wait_resp(1'b1, ok);
        vectors++;
        if (!ok || i_pmem_rdata !== pat_d) begin
            miscompares++;
            $display("FAIL b2b_i_resp: seen %b want 1", ok);
        end
        i_pmem_read = 1'b0;
        step();
        step();
    endtask

    task automatic test_starvation();
        bit ok;
        bit ok2;
        pmem_rdata     = pat_c;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0060;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_3000;
        for (int g = 0; g < 5; g++) begin
            wait_grant(ok);
            vectors++;
            if (g < 4) begin
                if (!ok || pmem_addr !== 32'h3000) begin
                    miscompares++;
                    $display("FAIL starve_grant%0d: seen %b addr %h want 1 00003000", g, ok, pmem_addr);
                end
            end else begin
                if (!ok || pmem_addr !== 32'h60) begin
                    miscompares++;
                    $display("FAIL starve_grant%0d: seen %b addr %h want 1 00000060", g, ok, pmem_addr);
                end
            end
            wait_resp(g == 4, ok2);
            if (!ok2) begin
                vectors++;
                miscompares++;
                $display("FAIL starve_resp%0d: timeout", g);
            end
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        step();
        vectors++;
        if (dut.starve_q !== 4'd0) begin
            miscompares++;
            $display("FAIL starve_clear: cnt %0d want 0", dut.starve_q);
        end
        step();
    endtask

    task automatic test_rw_conflict();
        bit ok;
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_2000;
        d_pmem_wdata   = pat_c;
        step();
        vectors++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h2000 || pmem_wdata !== pat_c) begin
            miscompares++;
            $display("FAIL rw_conflict: rd %b wr %b addr %h want 0 1 00002000", pmem_read, pmem_write, pmem_addr);
        end
        wait_resp(1'b0, ok);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL rw_conflict_resp: timeout");
        end
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_4000;
        step();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'h4000) begin
            miscompares++;
            $display("FAIL mid_grant: rd %b addr %h want 1 00004000", pmem_read, pmem_addr);
        end
        step();
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 ||
            pmem_addr !== '0 || pmem_wdata !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ctrl %b addr %h wdata_zero %b want 0000 0 1",
                     {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_addr, pmem_wdata === '0);
        end
        d_pmem_read = 1'b0;
        step();
        rst            = 1'b0;
        pmem_rdata     = pat_b;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_00A0;
        step();
        vectors++;
        if (pmem_read !== 1'b1 || pmem_addr !== 32'hA0) begin
            miscompares++;
            $display("FAIL post_reset_grant: rd %b addr %h want 1 000000a0", pmem_read, pmem_addr);
        end
        wait_resp(1'b1, ok);
        vectors++;
        if (!ok || i_pmem_rdata !== pat_b) begin
            miscompares++;
            $display("FAIL post_reset_resp: seen %b want 1", ok);
        end
        i_pmem_read = 1'b0;
        step();
        step();
    endtask

    task automatic test_spurious_resp();
        spur_resp = 1'b1;
        #1;
        vectors++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_resp: i %b d %b want 0 0", i_pmem_resp, d_pmem_resp);
        end
        step();
        spur_resp = 1'b0;
        step();
        vectors++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || dut.state_q !== arb_types::IDLE) begin
            miscompares++;
            $display("FAIL spurious_state: rd %b wr %b state %0d want 0 0 0", pmem_read, pmem_write, dut.state_q);
        end
    endtask

    initial begin
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'hB00B_1234}};
        pat_c = {8{32'hC3C3_5A5A}};
        pat_d = {8{32'hD00D_F00D}};
        rst            = 1'b1;
        spur_resp      = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;

        test_reset();
        test_i_read();
        test_back_to_back();
        test_starvation();
        test_rw_conflict();
        test_reset_mid_burst();
        test_spurious_resp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
